// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding, field widths and a small saturating helper
// shared by the alarm sequencer files.
package alarm_pkg;

   localparam int TIME_W = 8;
   localparam int SNZ_W  = 12;
   localparam int CNT_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_RING   = 2'd2,
      ST_SNOOZE = 2'd3
   } alarm_state_t;

   // Snooze counter stops at its all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/button_pulse.sv
// button_pulse: 2-FF synchronizer plus falling-edge detector for a raw
// active-low pushbutton; emits one registered pulse per press.
module button_pulse (
   input  logic CLK50,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   logic sync1;
   logic sync2;
   logic prev;

   // Everything presets to "released" so reset never looks like a press.
   always_ff @(posedge CLK50) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
         press <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         prev  <= sync2;
         press <= prev & ~sync2;
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: IDLE/ARMED/RINGING/SNOOZE alarm control for the 12-hour
// clock. Optional macro ALARM_SNOOZE_LIMIT_EN caps snoozes at MAX_SNOOZE.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int unsigned BLINK_CYC      = 25_000_000,
   parameter int unsigned SNOOZE_MIN     = 5,
   parameter int unsigned RING_TIMEOUT_S = 60,
   parameter int unsigned MAX_SNOOZE     = 3
) (
   input  logic              CLK50,
   input  logic              rst,
   input  logic              tick_1s,
   input  logic [TIME_W-1:0] hour,
   input  logic [TIME_W-1:0] min,
   input  logic [TIME_W-1:0] sec,
   input  logic [TIME_W-1:0] ahour,
   input  logic [TIME_W-1:0] amin,
   input  logic              arm,
   input  logic              snooze_n,
   input  logic              stop_n,
   output logic              ring,
   output logic              blink,
   output logic [1:0]        state,
   output logic [SNZ_W-1:0]  snooze_sec,
   output logic [CNT_W-1:0]  snooze_cnt
);

   localparam logic [SNZ_W-1:0]  SNZ_LOAD   = SNZ_W'(SNOOZE_MIN * 60);
   localparam logic [TIME_W-1:0] RING_LAST  = TIME_W'(RING_TIMEOUT_S - 1);
   localparam logic [31:0]       BLINK_LAST = 32'(BLINK_CYC - 1);

   alarm_state_t      cur, nxt;
   logic [SNZ_W-1:0]  ssec_q, ssec_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TIME_W-1:0] rsec_q, rsec_d;
   logic              blink_q, blink_d;
   logic [31:0]       bcnt_q, bcnt_d;
   logic              stop_press, snooze_press;
   logic              match, snooze_ok, enter_ring;

   button_pulse u_stop (
      .CLK50 (CLK50),
      .rst   (rst),
      .btn_n (stop_n),
      .press (stop_press)
   );

   button_pulse u_snooze (
      .CLK50 (CLK50),
      .rst   (rst),
      .btn_n (snooze_n),
      .press (snooze_press)
   );

   assign match = (hour == ahour) && (min == amin) && (sec == '0);

`ifdef ALARM_SNOOZE_LIMIT_EN
   assign snooze_ok = (32'(cnt_q) != MAX_SNOOZE);
`else
   assign snooze_ok = 1'b1;
`endif

   // Next-state logic; earlier branches win, so a press masks a same-cycle tick.
   always_comb begin
      nxt        = cur;
      ssec_d     = ssec_q;
      cnt_d      = cnt_q;
      rsec_d     = rsec_q;
      blink_d    = 1'b0;
      bcnt_d     = '0;
      enter_ring = 1'b0;
      unique case (cur)
         ST_IDLE: begin
            if (arm) nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (!arm) begin
               nxt = ST_IDLE;
            end else if (tick_1s && match) begin
               nxt        = ST_RING;
               cnt_d      = '0;
               enter_ring = 1'b1;
            end
         end
         ST_RING: begin
            if (!arm) begin
               nxt = ST_IDLE;
            end else if (stop_press) begin
               nxt = ST_ARMED;
            end else if (snooze_press && snooze_ok) begin
               nxt    = ST_SNOOZE;
               ssec_d = SNZ_LOAD;
               cnt_d  = sat_inc(cnt_q);
            end else begin
               if (tick_1s) begin
                  if (rsec_q == RING_LAST) nxt = ST_ARMED;
                  else rsec_d = rsec_q + 1'b1;
               end
               if (nxt == ST_RING) begin
                  if (bcnt_q == BLINK_LAST) begin
                     blink_d = ~blink_q;
                     bcnt_d  = '0;
                  end else begin
                     blink_d = blink_q;
                     bcnt_d  = bcnt_q + 32'd1;
                  end
               end
            end
         end
         ST_SNOOZE: begin
            if (!arm) begin
               nxt    = ST_IDLE;
               ssec_d = '0;
            end else if (stop_press) begin
               nxt    = ST_ARMED;
               ssec_d = '0;
            end else if (tick_1s) begin
               if (ssec_q == SNZ_W'(1)) begin
                  nxt        = ST_RING;
                  ssec_d     = '0;
                  enter_ring = 1'b1;
               end else begin
                  ssec_d = ssec_q - 1'b1;
               end
            end
         end
         default: nxt = ST_IDLE;
      endcase
      if (enter_ring) begin
         rsec_d  = '0;
         blink_d = 1'b1;
         bcnt_d  = '0;
      end
   end

   always_ff @(posedge CLK50) begin
      if (rst) begin
         cur     <= ST_IDLE;
         ssec_q  <= '0;
         cnt_q   <= '0;
         rsec_q  <= '0;
         blink_q <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         cur     <= nxt;
         ssec_q  <= ssec_d;
         cnt_q   <= cnt_d;
         rsec_q  <= rsec_d;
         blink_q <= blink_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign state      = cur;
   assign ring       = (cur == ST_RING);
   assign blink      = blink_q;
   assign snooze_sec = ssec_q;
   assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: table vectors, directed corner sequences and random
// stimulus, all checked against a behavioural alarm model.
module tb_alarm_sequencer;
   import alarm_pkg::*;

   localparam int unsigned BLINK = 4;
   localparam int unsigned SMIN  = 5;
   localparam int unsigned RTO   = 60;
   localparam int unsigned MAXS  = 3;

   logic        CLK50 = 1'b0;
   logic        rst = 1'b1;
   logic        tick_1s = 1'b0;
   logic        arm = 1'b0;
   logic        snooze_n = 1'b1;
   logic        stop_n = 1'b1;
   logic [7:0]  hour = 8'd5;
   logic [7:0]  min = 8'd59;
   logic [7:0]  sec = 8'd58;
   logic [7:0]  ahour = 8'd6;
   logic [7:0]  amin = 8'd0;
   logic        ring, blink;
   logic [1:0]  state, snooze_cnt;
   logic [11:0] snooze_sec;

   int total = 0;
   int bad = 0;

   // Model: mode 0..3 as seen on the state port, plus seconds/cycle counts.
   int mMode = 0;
   int mSnz = 0;
   int mCnt = 0;
   int mRingSec = 0;
   int mAge = 0;
   bit stopHist[4] = '{1, 1, 1, 1};
   bit snzHist[4]  = '{1, 1, 1, 1};

   typedef struct {
      bit rst;
      bit arm;
      bit tick;
      int hr;
      int mn;
      int sc;
      int expState;
      int expRing;
      int expBlink;
   } vec_t;

   vec_t vecs[14];

   always #5 CLK50 = ~CLK50;

   alarm_sequencer #(
      .BLINK_CYC      (BLINK),
      .SNOOZE_MIN     (SMIN),
      .RING_TIMEOUT_S (RTO),
      .MAX_SNOOZE     (MAXS)
   ) dut (
      .CLK50      (CLK50),
      .rst        (rst),
      .tick_1s    (tick_1s),
      .hour       (hour),
      .min        (min),
      .sec        (sec),
      .ahour      (ahour),
      .amin       (amin),
      .arm        (arm),
      .snooze_n   (snooze_n),
      .stop_n     (stop_n),
      .ring       (ring),
      .blink      (blink),
      .state      (state),
      .snooze_sec (snooze_sec),
      .snooze_cnt (snooze_cnt)
   );

   // A button press takes effect on the 4th edge after the pin first reads low.
   function automatic void modelEdge();
      bit stopPress, snzPress, hit, allowed;
      if (rst) begin
         mMode = 0; mSnz = 0; mCnt = 0; mRingSec = 0; mAge = 0;
         for (int i = 0; i < 4; i++) begin
            stopHist[i] = 1'b1;
            snzHist[i]  = 1'b1;
         end
         return;
      end
      stopPress = stopHist[0] && !stopHist[1];
      snzPress  = snzHist[0] && !snzHist[1];
      for (int i = 0; i < 3; i++) begin
         stopHist[i] = stopHist[i+1];
         snzHist[i]  = snzHist[i+1];
      end
      stopHist[3] = stop_n;
      snzHist[3]  = snooze_n;
      hit = tick_1s && (hour == ahour) && (min == amin) && (sec == 8'd0);
`ifdef ALARM_SNOOZE_LIMIT_EN
      allowed = (mCnt != int'(MAXS));
`else
      allowed = 1'b1;
`endif
      case (mMode)
         0: if (arm) mMode = 1;
         1: begin
            if (!arm) mMode = 0;
            else if (hit) begin
               mMode = 2; mCnt = 0; mRingSec = 0; mAge = 0;
            end
         end
         2: begin
            if (!arm) mMode = 0;
            else if (stopPress) mMode = 1;
            else if (snzPress && allowed) begin
               mMode = 3;
               mSnz  = int'(SMIN) * 60;
               mCnt  = (mCnt < 3) ? mCnt + 1 : 3;
            end else if (tick_1s && mRingSec == int'(RTO) - 1) mMode = 1;
            else begin
               if (tick_1s) mRingSec++;
               mAge++;
            end
         end
         default: begin
            if (!arm || stopPress) begin
               mMode = arm ? 1 : 0;
               mSnz  = 0;
            end else if (tick_1s) begin
               if (mSnz == 1) begin
                  mMode = 2; mSnz = 0; mRingSec = 0; mAge = 0;
               end else begin
                  mSnz--;
               end
            end
         end
      endcase
   endfunction

   task automatic checkVal(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic checkOutput(input string tag);
      int expBlink;
      expBlink = (mMode == 2 && ((mAge / int'(BLINK)) % 2) == 0) ? 1 : 0;
      checkVal({tag, ".state"}, int'(state), mMode);
      checkVal({tag, ".ring"}, int'(ring), (mMode == 2) ? 1 : 0);
      checkVal({tag, ".blink"}, int'(blink), expBlink);
      checkVal({tag, ".snooze_sec"}, int'(snooze_sec), (mMode == 3) ? mSnz : 0);
      checkVal({tag, ".snooze_cnt"}, int'(snooze_cnt), mCnt);
   endtask

   task automatic applyStimulus(input string tag);
      @(posedge CLK50);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus("idle");
   endtask

   task automatic runTicks(input int n);
      tick_1s = 1'b1;
      repeat (n) applyStimulus("tick");
      tick_1s = 1'b0;
   endtask

   task automatic pressSnooze();
      snooze_n = 1'b0;
      repeat (4) applyStimulus("snzp");
      snooze_n = 1'b1;
      idleCycles(2);
   endtask

   initial begin
      vecs[0]  = '{1, 0, 0, 5, 59, 58, 0, 0, 0};
      vecs[1]  = '{1, 1, 0, 5, 59, 58, 0, 0, 0};
      vecs[2]  = '{0, 1, 0, 5, 59, 58, 1, 0, 0};
      vecs[3]  = '{0, 1, 1, 5, 59, 59, 1, 0, 0};
      vecs[4]  = '{0, 1, 0, 6, 0, 0, 1, 0, 0};
      vecs[5]  = '{0, 1, 1, 6, 0, 0, 2, 1, 1};
      vecs[6]  = '{0, 1, 0, 6, 0, 0, 2, 1, 1};
      vecs[7]  = '{0, 1, 0, 6, 0, 0, 2, 1, 1};
      vecs[8]  = '{0, 1, 0, 6, 0, 0, 2, 1, 1};
      vecs[9]  = '{0, 1, 0, 6, 0, 0, 2, 1, 0};
      vecs[10] = '{0, 1, 0, 6, 0, 0, 2, 1, 0};
      vecs[11] = '{0, 1, 0, 6, 0, 0, 2, 1, 0};
      vecs[12] = '{0, 1, 0, 6, 0, 0, 2, 1, 0};
      vecs[13] = '{0, 1, 0, 6, 0, 0, 2, 1, 1};

      for (int i = 0; i < 14; i++) begin
         rst     = vecs[i].rst;
         arm     = vecs[i].arm;
         tick_1s = vecs[i].tick;
         hour    = 8'(vecs[i].hr);
         min     = 8'(vecs[i].mn);
         sec     = 8'(vecs[i].sc);
         applyStimulus($sformatf("vec%0d", i));
         checkVal($sformatf("vec%0d.tstate", i), int'(state), vecs[i].expState);
         checkVal($sformatf("vec%0d.tring", i), int'(ring), vecs[i].expRing);
         checkVal($sformatf("vec%0d.tblink", i), int'(blink), vecs[i].expBlink);
      end
      tick_1s = 1'b0;

      // Snooze press latency, hold without repeat, full countdown back to ringing.
      snooze_n = 1'b0;
      repeat (3) applyStimulus("snzlat");
      checkVal("snz.lat3", int'(state), 2);
      applyStimulus("snzlat");
      checkVal("snz.state", int'(state), 3);
      checkVal("snz.sec", int'(snooze_sec), 300);
      checkVal("snz.cnt", int'(snooze_cnt), 1);
      idleCycles(3);
      checkVal("snz.hold", int'(snooze_cnt), 1);
      snooze_n = 1'b1;
      idleCycles(2);
      runTicks(299);
      checkVal("snz.299", int'(state), 3);
      checkVal("snz.299sec", int'(snooze_sec), 1);
      runTicks(1);
      checkVal("snz.back", int'(state), 2);
      checkVal("snz.backsec", int'(snooze_sec), 0);

      // Auto-stop after the 60th tick, then no retrigger a minute later.
      runTicks(59);
      checkVal("to.59", int'(state), 2);
      runTicks(1);
      checkVal("to.60", int'(state), 1);
      checkVal("to.ring", int'(ring), 0);
      min = 8'd1;
      runTicks(1);
      checkVal("to.noretrig", int'(state), 1);

      // Snooze press coinciding with a tick.
      min = 8'd0;
      runTicks(1);
      checkVal("st.ring", int'(state), 2);
      checkVal("st.cnt0", int'(snooze_cnt), 0);
      snooze_n = 1'b0;
      repeat (3) applyStimulus("st");
      tick_1s = 1'b1;
      applyStimulus("st");
      tick_1s = 1'b0;
      checkVal("st.state", int'(state), 3);
      checkVal("st.sec", int'(snooze_sec), 300);
      snooze_n = 1'b1;
      idleCycles(2);

      // Disarm during snooze, then stop+snooze together while ringing.
      arm = 1'b0;
      applyStimulus("disarm");
      checkVal("dis.state", int'(state), 0);
      checkVal("dis.sec", int'(snooze_sec), 0);
      arm = 1'b1;
      applyStimulus("rearm");
      checkVal("rearm.state", int'(state), 1);
      runTicks(1);
      checkVal("both.ring", int'(state), 2);
      stop_n = 1'b0;
      snooze_n = 1'b0;
      repeat (4) applyStimulus("both");
      checkVal("both.state", int'(state), 1);
      checkVal("both.sec", int'(snooze_sec), 0);
      stop_n = 1'b1;
      snooze_n = 1'b1;
      idleCycles(2);

      // Four snoozes in one alarm event.
      runTicks(1);
      checkVal("lim.ring", int'(state), 2);
      for (int k = 0; k < 3; k++) begin
         pressSnooze();
         checkVal($sformatf("lim.snz%0d", k), int'(state), 3);
         checkVal($sformatf("lim.cnt%0d", k), int'(snooze_cnt), k + 1);
         runTicks(300);
         checkVal($sformatf("lim.back%0d", k), int'(state), 2);
      end
      snooze_n = 1'b0;
      repeat (4) applyStimulus("lim4");
      snooze_n = 1'b1;
`ifdef ALARM_SNOOZE_LIMIT_EN
      checkVal("lim.4th", int'(state), 2);
`else
      checkVal("lim.4th", int'(state), 3);
`endif
      checkVal("lim.cnt4", int'(snooze_cnt), 3);
      idleCycles(2);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 99) == 0) arm = ~arm;
         tick_1s = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) snooze_n = ~snooze_n;
         if ($urandom_range(0, 39) == 0) stop_n = ~stop_n;
         if ($urandom_range(0, 199) == 0) begin
            ahour = 8'($urandom_range(1, 12));
            amin  = 8'($urandom_range(0, 59));
         end
         hour = ($urandom_range(0, 1) == 0) ? ahour : 8'($urandom_range(1, 12));
         min  = ($urandom_range(0, 1) == 0) ? amin : 8'($urandom_range(0, 59));
         sec  = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 59));
         applyStimulus("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
